// File: rtl/exe_mem_pipe_pkg.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe_pkg
// Shared widths, the idle memory-op encoding and the skid-buffer state type
// used by the EXE->MEM pipeline register and its skid buffer.
// -----------------------------------------------------------------------------
package exe_mem_pipe_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;
    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int MEMOP_WIDTH = 4;

    // Memory op presented to MEM whenever the head entry is not valid.
    localparam logic [MEMOP_WIDTH-1:0] MEM_NOP = '0;

    // Occupancy of the 2-entry skid buffer.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,  // head invalid, skid invalid
        SKID_ONE   = 2'd1,  // head valid,   skid invalid
        SKID_TWO   = 2'd2   // head valid,   skid valid
    } skid_state_e;

endpackage

// File: rtl/exe_mem_pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic 2-entry valid/ready skid buffer. The head register drives the
// output; the skid register absorbs one extra beat so that in_ready_o can be
// a register instead of a combinational function of out_ready_i.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         drop every held entry (and any beat accepted this cycle)
//   in_valid_i      upstream presents in_data_i
//   in_ready_o      registered; low only while both entries are occupied
//   in_data_i       W-bit payload
//   out_valid_o     head entry valid
//   out_ready_i     downstream consumes the head this cycle
//   out_data_o      head payload (holds its last value while invalid)
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import exe_mem_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    skid_state_e  r_state;
    logic         r_in_ready;
    logic [W-1:0] r_head_p1;
    logic [W-1:0] r_skid_p1;

    logic w_in_fire;
    logic w_out_fire;
    logic w_skid_load;

    assign w_in_fire   = in_valid_i & r_in_ready;
    assign w_out_fire  = (r_state != SKID_EMPTY) & out_ready_i;
    // Skid only captures when the head is occupied and is not draining.
    assign w_skid_load = !rst_i && !flush_i && (r_state == SKID_ONE)
                         && w_in_fire && !w_out_fire;

    // ---- stage p1: occupancy control and head register ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b1;
            r_head_p1  <= '0;
        end else if (flush_i) begin
            // Head data is left alone; only validity is dropped.
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        r_head_p1 <= in_data_i;
                        r_state   <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_head_p1 <= in_data_i;
                    end else if (w_in_fire) begin
                        r_state    <= SKID_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state <= SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready_o is low here, so only a drain can happen.
                    if (w_out_fire) begin
                        r_head_p1  <= r_skid_p1;
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= SKID_EMPTY;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Skid data carries no reset; it is never read while the skid is invalid.
    always_ff @(posedge clk_i) begin
        if (w_skid_load) begin
            r_skid_p1 <= in_data_i;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = (r_state != SKID_EMPTY);
    assign out_data_o  = r_head_p1;

endmodule

// File: rtl/exe_mem_pipe.sv
// -----------------------------------------------------------------------------
// exe_mem_pipe
// EXE->MEM pipeline register built around a 2-entry skid buffer. Carries the
// register-writeback and memory-access payload, gates write enables and the
// memory op while the head is invalid, exposes a forwarding tap for hazard
// bypass and counts back-pressure cycles with a saturating counter.
//
// Ports
//   clk_i, rst_i, flush_i          clock, sync active-high reset, flush
//   in_valid_i / in_ready_o        EXE-side handshake (in_ready_o registered)
//   reg_*_i, mem_*_i               EXE payload
//   out_valid_o / out_ready_i      MEM-side handshake
//   reg_*_o, mem_*_o               head payload toward MEM
//   fwd_valid_o/waddr_o/wdata_o    head register write, for bypass
//   stall_cnt_o                    cycles with out_valid_o=1 and out_ready_i=0
// -----------------------------------------------------------------------------
module exe_mem_pipe
    import exe_mem_pipe_pkg::*;
#(
    parameter int RADDR_W = RADDR_WIDTH,
    parameter int RDATA_W = RDATA_WIDTH,
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int MEMOP_W = MEMOP_WIDTH,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               reg_we_i,
    input  logic [RDATA_W-1:0] reg_wdata_i,
    input  logic               mem_we_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_data_i,
    input  logic [MEMOP_W-1:0] mem_op_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               reg_we_o,
    output logic [RDATA_W-1:0] reg_wdata_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_data_o,
    output logic [MEMOP_W-1:0] mem_op_o,
    output logic               fwd_valid_o,
    output logic [RADDR_W-1:0] fwd_waddr_o,
    output logic [RDATA_W-1:0] fwd_wdata_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    localparam int PAY_W = RADDR_W + 1 + RDATA_W + 1 + ADDR_W + DATA_W + MEMOP_W;
    localparam logic [MEMOP_W-1:0] L_NOP = MEMOP_W'(MEM_NOP);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [PAY_W-1:0]   w_in_pay;
    logic [PAY_W-1:0]   w_head_pay;
    logic               w_head_vld;

    logic [RADDR_W-1:0] w_h_waddr;
    logic               w_h_reg_we;
    logic [RDATA_W-1:0] w_h_wdata;
    logic               w_h_mem_we;
    logic [ADDR_W-1:0]  w_h_addr;
    logic [DATA_W-1:0]  w_h_data;
    logic [MEMOP_W-1:0] w_h_op;

    logic [CNT_W-1:0]   r_stall_cnt;

    assign w_in_pay = {reg_waddr_i, reg_we_i, reg_wdata_i, mem_we_i,
                       mem_addr_i, mem_data_i, mem_op_i};

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (w_in_pay),
        .out_valid_o (w_head_vld),
        .out_ready_i (out_ready_i),
        .out_data_o  (w_head_pay)
    );

    assign {w_h_waddr, w_h_reg_we, w_h_wdata, w_h_mem_we,
            w_h_addr, w_h_data, w_h_op} = w_head_pay;

    // Side effects are suppressed while the head is invalid; address and
    // data fields simply show whatever the head last held.
    assign out_valid_o = w_head_vld;
    assign reg_waddr_o = w_h_waddr;
    assign reg_we_o    = w_head_vld & w_h_reg_we;
    assign reg_wdata_o = w_h_wdata;
    assign mem_we_o    = w_head_vld & w_h_mem_we;
    assign mem_addr_o  = w_h_addr;
    assign mem_data_o  = w_h_data;
    assign mem_op_o    = w_head_vld ? w_h_op : L_NOP;

    assign fwd_valid_o = w_head_vld & w_h_reg_we;
    assign fwd_waddr_o = w_h_waddr;
    assign fwd_wdata_o = w_h_wdata;

    // ---- stall counter: counts on flush cycles too ----
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_head_vld && !out_ready_i) begin
            r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    assign stall_cnt_o = r_stall_cnt;

endmodule
